count_sequencer: RTL
====================

// Module: count_sequencer
// PURPOSE
//  Run/pause/clear controller for the 2-digit BCD up/down display counter.
//  Debounces the start/stop and clear push-buttons and synchronises the direction switch.
//  Sequences the counter with a 3-state FSM plus a transient CLEAR state.
//  Issues one-cycle count-enable ticks at a programmable rate. Sits between board I/O and the counter datapath.
// PARAMETERS
//  DEB_CYCLES  20000    consecutive stable cycles needed to accept a button level change (>=2)
//  DEB_W       15       width of debounce counters; must hold DEB_CYCLES-1
//  TICK_DIV    1000000  clk cycles per count tick while running (>=2)
//  DIV_W       20       width of tick divider; must hold TICK_DIV-1
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous reset, active-high
//  btn_start  in   1  start/stop push-button, async, active-high, bouncy
//  btn_clear  in   1  clear push-button, async, active-high, bouncy
//  dir_sw     in   1  direction switch, async: 1 = up, 0 = down
//  cnt_en     out  1  one-cycle pulse: counter advances one step
//  cnt_dir    out  1  direction to counter, synchronised copy of dir_sw
//  cnt_clr    out  1  one-cycle pulse: counter loads 00
//  run_led    out  1  high while state == RUN
//  state      out  2  IDLE=00 RUN=01 PAUSE=10 CLEAR=11
// BEHAVIOUR
//  Reset: rst high at an edge forces state=IDLE; cnt_en, cnt_clr, run_led, cnt_dir=0.
//   Also clears sync flops, debounced levels, debounce counters and divider; wins over everything.
//   Mid-operation reset: same result, no tick or clear pulse emitted.
//  Sync: every async input passes two flops (s1->s2); cnt_dir = s2 of dir_sw, 2-edge latency.
//  Debounce, per button: cnt cleared whenever s2 == deb_level.
//   Otherwise cnt increments; when cnt == DEB_CYCLES-1 and s2 still differs:
//   deb_level <= s2, cnt <= 0.
//   Result: a level held DEB_CYCLES edges after reaching s2 is accepted; shorter glitches are ignored.
//  Press event = deb_level & ~deb_level_q (rising edge only); releases produce no event.
//  FSM (registered, one transition per edge, priority top-down):
//   clear press in any state (incl. CLEAR) -> CLEAR
//   CLEAR -> IDLE unconditionally next edge
//   IDLE  + start press -> RUN (divider = 0)
//   RUN   + start press -> PAUSE (divider holds value)
//   PAUSE + start press -> RUN (divider resumes from held value; tick phase preserved)
//   Simultaneous start and clear presses: clear wins, start is discarded.
//  Divider: in IDLE/CLEAR it is forced to 0; in PAUSE it holds.
//   In RUN it increments each edge; at TICK_DIV-1 it wraps to 0 and cnt_en <= 1 for one cycle.
//   cnt_en is never high outside the cycle after a wrap, so tick period = TICK_DIV cycles.
//  cnt_clr: registered; high exactly the cycle state==CLEAR, i.e. one cycle per clear press.
//   cnt_en is 0 in that cycle.
//  run_led: registered decode of next state, so it is coincident with state==RUN.
//  Direction changes apply from the next cnt_en; no tick is generated or dropped by a change.
// TESTING (bench with DEB_CYCLES=4, TICK_DIV=8)
//  Reset: rst=1 for 2 edges, then 0 -> state=00; cnt_en, cnt_clr, run_led, cnt_dir all 0.
//  Start: btn_start=1 before edge 1, held -> state=01 after edge 7.
//   First cnt_en after edge 15, then every 8 cycles, each 1 cycle wide.
//  Bounce: btn_start high 3 cycles then low, repeated 5 times -> state stays 00, no cnt_en.
//  Pause/resume: press start with divider=5 in RUN -> PAUSE, divider held at 5, no cnt_en.
//   Press again -> RUN; first cnt_en exactly 3 cycles after RUN entry.
//  Clear priority: both buttons pressed in same cycle while RUN -> one CLEAR cycle with cnt_clr=1.
//   Then state=00, no PAUSE; cnt_en=0 throughout.
//  Direction: toggle dir_sw mid-RUN -> cnt_dir follows 2 edges later; tick spacing still 8.

Source files
------------

// File: rtl/count_sequencer.sv
// count_sequencer
//   Run/pause/clear controller for a 2-digit BCD up/down display counter.
//   It debounces the start/stop and clear push-buttons and synchronises the
//   direction switch. An IDLE/RUN/PAUSE FSM, plus a one-cycle CLEAR state,
//   sequences the counter. While running, a divider issues one-cycle
//   count-enable ticks every TICK_DIV cycles.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high, overrides everything
//   btn_start  in   start/stop push-button (async, bouncy, active-high)
//   btn_clear  in   clear push-button (async, bouncy, active-high)
//   dir_sw     in   direction switch (async), 1 = up, 0 = down
//   cnt_en     out  one-cycle pulse, counter advances one step
//   cnt_dir    out  synchronised copy of dir_sw
//   cnt_clr    out  one-cycle pulse, counter loads 00
//   run_led    out  high while state == RUN
//   state      out  IDLE=00 RUN=01 PAUSE=10 CLEAR=11
module count_sequencer #(
  parameter int unsigned DEB_CYCLES = 20000,
  parameter int unsigned DEB_W      = 15,
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned DIV_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       dir_sw,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic       run_led,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StClear = 2'b11
  } state_t;

  localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for every asynchronous input
  // ---------------------------------------------------------------------------
  logic start_s1_q, start_s2_q;
  logic clear_s1_q, clear_s2_q;
  logic dir_s1_q, dir_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      clear_s1_q <= 1'b0;
      clear_s2_q <= 1'b0;
      dir_s1_q   <= 1'b0;
      dir_s2_q   <= 1'b0;
    end else begin
      start_s1_q <= btn_start;
      start_s2_q <= start_s1_q;
      clear_s1_q <= btn_clear;
      clear_s2_q <= clear_s1_q;
      dir_s1_q   <= dir_sw;
      dir_s2_q   <= dir_s1_q;
    end
  end

  assign cnt_dir = dir_s2_q;

  // ---------------------------------------------------------------------------
  // Debouncers: a new level is accepted only after it has differed from the
  // accepted level for DEB_CYCLES consecutive edges. Any return to the
  // accepted level restarts the count.
  // ---------------------------------------------------------------------------
  logic             start_lvl_q, start_lvl_d, start_lvl_prev_q;
  logic [DEB_W-1:0] start_cnt_q, start_cnt_d;
  logic             clear_lvl_q, clear_lvl_d, clear_lvl_prev_q;
  logic [DEB_W-1:0] clear_cnt_q, clear_cnt_d;

  always_comb begin
    start_lvl_d = start_lvl_q;
    start_cnt_d = start_cnt_q;
    if (start_s2_q == start_lvl_q) begin
      start_cnt_d = '0;
    end else if (start_cnt_q == DebLast) begin
      start_lvl_d = start_s2_q;
      start_cnt_d = '0;
    end else begin
      start_cnt_d = start_cnt_q + DEB_W'(1);
    end
  end

  always_comb begin
    clear_lvl_d = clear_lvl_q;
    clear_cnt_d = clear_cnt_q;
    if (clear_s2_q == clear_lvl_q) begin
      clear_cnt_d = '0;
    end else if (clear_cnt_q == DebLast) begin
      clear_lvl_d = clear_s2_q;
      clear_cnt_d = '0;
    end else begin
      clear_cnt_d = clear_cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_lvl_q      <= 1'b0;
      start_lvl_prev_q <= 1'b0;
      start_cnt_q      <= '0;
      clear_lvl_q      <= 1'b0;
      clear_lvl_prev_q <= 1'b0;
      clear_cnt_q      <= '0;
    end else begin
      start_lvl_q      <= start_lvl_d;
      start_lvl_prev_q <= start_lvl_q;
      start_cnt_q      <= start_cnt_d;
      clear_lvl_q      <= clear_lvl_d;
      clear_lvl_prev_q <= clear_lvl_q;
      clear_cnt_q      <= clear_cnt_d;
    end
  end

  // Press events fire on the accepted rising edge only. Releases are ignored.
  logic start_press, clear_press;
  assign start_press = start_lvl_q & ~start_lvl_prev_q;
  assign clear_press = clear_lvl_q & ~clear_lvl_prev_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM, in priority order: clear press, leave CLEAR, start press
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clear_press) begin
      state_d = StClear;
    end else if (state_q == StClear) begin
      state_d = StIdle;
    end else if (start_press) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        StClear: state_d = StIdle;
      endcase
    end
  end

  // The divider advances only on edges that both start and stay in RUN.
  // Entering RUN from PAUSE resumes from the held value, so the tick phase is
  // preserved. Leaving RUN holds the value the divider had before the edge.
  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      run_led <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_en  <= 1'b0;
      unique case (state_d)
        StIdle, StClear: div_q <= '0;
        StRun: begin
          if (state_q == StRun) begin
            if (div_q == DivLast) begin
              div_q  <= '0;
              cnt_en <= 1'b1;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
        end
        StPause: div_q <= div_q;
      endcase
      cnt_clr <= (state_d == StClear);
      run_led <= (state_d == StRun);
    end
  end

  assign state = state_q;

endmodule
